// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-slices a shared 7-segment bus across four
// active-low digit enables. Each digit slot has a short blank phase followed by
// a show phase. New frames arrive through a valid/ready handshake into a shadow
// buffer, and are promoted to the active frame only at frame boundaries.
// Optional feature macro: SEG_SCAN_BRIGHTNESS_PWM_EN (adds brightness[3:0] and
// PWM-gates the digit enable inside the show phase).
module seg_scan_controller #(
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        scan_enable,
  input  logic [27:0] frame_data,
  input  logic        frame_valid,
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
  input  logic [3:0]  brightness,
`endif
  output logic        frame_ready,
  output logic        frame_tick,
  output logic        DS_EN1,
  output logic        DS_EN2,
  output logic        DS_EN3,
  output logic        DS_EN4,
  output logic        DS_A,
  output logic        DS_B,
  output logic        DS_C,
  output logic        DS_D,
  output logic        DS_E,
  output logic        DS_F,
  output logic        DS_G
);

  localparam int CNT_W       = $clog2(DWELL_CYCLES);
  localparam int SHOW_CYCLES = DWELL_CYCLES - BLANK_CYCLES;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  if ((DWELL_CYCLES <= BLANK_CYCLES) || (DWELL_CYCLES < 4) || (BLANK_CYCLES < 1)) begin : g_bad_params
    $error("seg_scan_controller: need DWELL_CYCLES > BLANK_CYCLES, DWELL_CYCLES >= 4, BLANK_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [27:0]      active_q, active_d;
  logic [27:0]      shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             frame_ready_q, frame_ready_d;
  logic             frame_tick_q, frame_tick_d;
  logic [3:0]       ds_en_q, ds_en_d;
  logic [6:0]       seg_q, seg_d;

  logic             boundary;
  logic             frame_start;
  logic             load_shadow;
  logic             accept;
  logic             digit_on_d;

`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0]       bright_q, bright_d;
  logic [CNT_W-1:0] show_cnt_d;

  // Number of show-phase cycles the digit stays lit at a given brightness.
  function automatic logic [CNT_W-1:0] pwm_limit(input logic [3:0] br);
    int prod;
    prod = (int'(br) + 1) * SHOW_CYCLES;
    return CNT_W'(prod / 16);
  endfunction
`endif

  // Segment mask of one digit; digit 0 is the low 7 bits of the frame.
  function automatic logic [6:0] digit_mask(input logic [27:0] frame, input logic [1:0] idx);
    logic [6:0] m;
    m = frame[6:0];
    case (idx)
      2'd0:    m = frame[6:0];
      2'd1:    m = frame[13:7];
      2'd2:    m = frame[20:14];
      default: m = frame[27:21];
    endcase
    return m;
  endfunction

  // Next-state, handshake and output decode; outputs are computed from the
  // next state so the registered outputs always match the state register.
  always_comb begin
    boundary    = (state_q == S_SHOW) && (digit_q == 2'd3) && (cnt_q == CNT_LAST);
    frame_start = scan_enable && ((state_q == S_IDLE) || boundary);
    load_shadow = frame_start && shadow_full_q;
    accept      = frame_valid && frame_ready_q;

    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;

    if (!scan_enable) begin
      state_d = S_IDLE;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          digit_d = '0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          digit_d = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // The boundary load sees only the pre-edge shadow; a frame accepted in
    // the same cycle lands in the (then empty) shadow for the next boundary.
    active_d      = load_shadow ? shadow_q : active_q;
    shadow_d      = accept ? frame_data : shadow_q;
    shadow_full_d = (shadow_full_q && !load_shadow) || accept;
    frame_ready_d = !shadow_full_d;

`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
    bright_d   = frame_start ? brightness : bright_q;
    show_cnt_d = cnt_d - CNT_W'(BLANK_CYCLES);
    digit_on_d = (show_cnt_d < pwm_limit(bright_d));
`else
    digit_on_d = 1'b1;
`endif

    frame_tick_d = (state_d == S_SHOW) && (digit_d == 2'd3) && (cnt_d == CNT_LAST);
    seg_d        = (state_d == S_IDLE) ? 7'd0 : digit_mask(active_d, digit_d);
    ds_en_d      = 4'hF;
    if ((state_d == S_SHOW) && digit_on_d) begin
      ds_en_d[digit_d] = 1'b0;
    end
  end

  // FSM state, active frame and registered outputs; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      digit_q       <= '0;
      cnt_q         <= '0;
      active_q      <= '0;
      shadow_full_q <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      ds_en_q       <= 4'hF;
      seg_q         <= '0;
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
      bright_q      <= 4'hF;
`endif
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
      frame_ready_q <= frame_ready_d;
      frame_tick_q  <= frame_tick_d;
      ds_en_q       <= ds_en_d;
      seg_q         <= seg_d;
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
      bright_q      <= bright_d;
`endif
    end
  end

  // Shadow payload; validity is tracked by shadow_full_q, so no reset needed.
  always_ff @(posedge CLK) begin
    shadow_q <= shadow_d;
  end

  assign frame_ready = frame_ready_q;
  assign frame_tick  = frame_tick_q;
  assign DS_EN1      = ds_en_q[0];
  assign DS_EN2      = ds_en_q[1];
  assign DS_EN3      = ds_en_q[2];
  assign DS_EN4      = ds_en_q[3];
  assign DS_A        = seg_q[6];
  assign DS_B        = seg_q[5];
  assign DS_C        = seg_q[4];
  assign DS_D        = seg_q[3];
  assign DS_E        = seg_q[2];
  assign DS_F        = seg_q[1];
  assign DS_G        = seg_q[0];

endmodule

// File: tb/tb_seg_scan_controller.sv
// Testbench for seg_scan_controller (DWELL_CYCLES=16, BLANK_CYCLES=2).
// Directed table vectors and hand sequences, then randomized stimulus compared
// against a frame-position reference model.
module tb_seg_scan_controller;

  localparam int D  = 16;
  localparam int B  = 2;
  localparam int FP = 4 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        valid = 1'b0;
  logic [27:0] data = '0;
  logic        ready, tick;
  logic        en1, en2, en3, en4;
  logic        sa, sb, sc, sd, se, sf, sg;
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0]  bright = 4'hF;
`endif

  always #5 clk = ~clk;

  seg_scan_controller #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .CLK(clk), .RST_N(rst_n), .scan_enable(scan_en),
    .frame_data(data), .frame_valid(valid),
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
    .brightness(bright),
`endif
    .frame_ready(ready), .frame_tick(tick),
    .DS_EN1(en1), .DS_EN2(en2), .DS_EN3(en3), .DS_EN4(en4),
    .DS_A(sa), .DS_B(sb), .DS_C(sc), .DS_D(sd), .DS_E(se), .DS_F(sf), .DS_G(sg)
  );

  wire [3:0] en  = {en4, en3, en2, en1};
  wire [6:0] seg = {sa, sb, sc, sd, se, sf, sg};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: scanning is described by the position m_t inside the frame.
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [27:0] m_active = '0;
  logic [27:0] m_shadow[$];
  bit          m_ready = 1'b0;
  int          m_bright = 15;

  function automatic bit pwm_ok(int s);
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
    return s < (((m_bright + 1) * (D - B)) / 16);
`else
    return s >= 0;
`endif
  endfunction

  function automatic logic [3:0] m_en();
    logic [3:0] r;
    int slot, pos;
    r = 4'hF;
    if (m_run) begin
      slot = m_t / D;
      pos  = m_t % D;
      if (pos >= B && pwm_ok(pos - B)) r = ~(4'b0001 << slot);
    end
    return r;
  endfunction

  function automatic logic [6:0] m_seg();
    if (!m_run) return 7'd0;
    return m_active[(m_t / D) * 7 +: 7];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Apply current inputs across one clock edge and advance the model.
  task automatic step();
    bit r, s, v, acc;
    logic [27:0] d;
    int br;
    r = rst_n; s = scan_en; v = valid; d = data;
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
    br = int'(bright);
`else
    br = 15;
`endif
    @(posedge clk);
    #1;
    if (!r) begin
      m_run = 1'b0; m_t = 0; m_active = '0; m_shadow.delete(); m_ready = 1'b0; m_bright = 15;
    end else begin
      acc = v && m_ready;
      if (m_run && !s) begin
        m_run = 1'b0; m_t = 0;
      end else if (m_run) begin
        if (m_t == FP - 1) begin
          if (m_shadow.size() > 0) m_active = m_shadow.pop_front();
          m_bright = br;
        end
        m_t = (m_t + 1) % FP;
      end else if (s) begin
        m_run = 1'b1; m_t = 0;
        if (m_shadow.size() > 0) m_active = m_shadow.pop_front();
        m_bright = br;
      end
      if (acc) m_shadow.push_back(d);
      m_ready = (m_shadow.size() == 0);
    end
  endtask

  task automatic cmp_all();
    check("rand_en", en, m_en());
    check("rand_seg", seg, m_seg());
    check("rand_tick", tick, (m_run && m_t == FP - 1));
    check("rand_ready", ready, m_ready);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; scan_en = 1'b0; valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_to(input int tgt);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_run && m_t == tgt) && n < 300);
    if (!(m_run && m_t == tgt)) begin
      n_tests++; n_fail++;
      $display("FAIL run_to: cycle budget expired, position %0d wanted %0d", m_t, tgt);
    end
  endtask

  typedef struct {
    logic [27:0] frame;
    logic [6:0]  e1, e2, e3, e4;
  } vec_t;

  function automatic logic [6:0] pick(input vec_t v, input int k);
    case (k)
      0: return v.e1;
      1: return v.e2;
      2: return v.e3;
      default: return v.e4;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[3];
    logic [3:0]  pat[4];
    logic [27:0] fb, fc, fd;
    int          n, ticks, lows;

    vecs[0] = '{frame: {7'h7E, 7'h30, 7'h6D, 7'h79}, e1: 7'h79, e2: 7'h6D, e3: 7'h30, e4: 7'h7E};
    vecs[1] = '{frame: {7'h7F, 7'h00, 7'h7F, 7'h00}, e1: 7'h00, e2: 7'h7F, e3: 7'h00, e4: 7'h7F};
    vecs[2] = '{frame: {7'h01, 7'h02, 7'h40, 7'h5B}, e1: 7'h5B, e2: 7'h40, e3: 7'h02, e4: 7'h01};
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    fb = {7'h06, 7'h5B, 7'h4F, 7'h66};
    fc = {7'h6D, 7'h7D, 7'h07, 7'h7F};
    fd = {7'h11, 7'h22, 7'h33, 7'h44};

    // Reset with scan_enable and frame_valid held high.
    rst_n = 1'b0; scan_en = 1'b1; valid = 1'b1; data = vecs[0].frame;
    step(); step();
    check("rst_en", en, 4'hF);
    check("rst_seg", seg, 7'h00);
    check("rst_ready", ready, 1'b0);
    check("rst_tick", tick, 1'b0);
    rst_n = 1'b1;
    step();
    check("rel_ready", ready, 1'b1);
    check("rel_en", en, 4'hF);

    // Table vectors: load from IDLE, then two full frames of scanning.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      data = vecs[v].frame; valid = 1'b1;
      step();
      check("load_ready_low", ready, 1'b0);
      valid = 1'b0; scan_en = 1'b1;
      step();
      check("start_ready", ready, 1'b1);
      for (int cyc = 0; cyc < 2 * FP; cyc++) begin
        int p, k;
        p = cyc % D;
        k = (cyc / D) % 4;
        if (p == 0) begin
          check("blank_en", en, 4'hF);
          check("blank_seg", seg, pick(vecs[v], k));
        end
        if (p == B) begin
          check("show_en", en, pat[k]);
          check("show_seg", seg, pick(vecs[v], k));
        end
        if (p == D - 2) check("tick_early", tick, 1'b0);
        if (p == D - 1) begin
          check("last_en", en, pat[k]);
          check("tick_slot", tick, (k == 3));
        end
        step();
      end
    end

    // Mid-frame B accepted at once; C stalls until after the boundary.
    run_to(20);
    data = fb; valid = 1'b1;
    step();
    check("b_accept_ready", ready, 1'b0);
    data = fc;
    n = 0;
    while (tick !== 1'b1 && n < 100) begin
      step();
      check("c_stalled", ready, 1'b0);
      n++;
    end
    check("b_tick_seen", tick, 1'b1);
    check("b_old_digit4", seg, vecs[2].e4);
    step();
    check("b_ready_rise", ready, 1'b1);
    check("b_digit1_blank", seg, 7'h66);
    step();
    check("c_accepted", ready, 1'b0);
    valid = 1'b0;
    step();
    check("b_show_en", en, 4'b1110);
    check("b_show_seg", seg, 7'h66);
    run_to(0);
    check("c_applied", seg, 7'h7F);
    check("c_ready", ready, 1'b1);

    // Drop scan_enable during digit 3 show.
    run_to(37);
    check("d3_en", en, 4'b1011);
    scan_en = 1'b0;
    step();
    check("drop_en", en, 4'hF);
    check("drop_seg", seg, 7'h00);
    check("drop_tick", tick, 1'b0);
    ticks = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tick !== 1'b0 || en !== 4'hF) ticks++;
    end
    check("idle_quiet", ticks, 0);
    scan_en = 1'b1;
    step();
    check("reen_blank", en, 4'hF);
    step(); step();
    check("reen_en", en, 4'b1110);
    check("reen_seg", seg, 7'h7F);

    // One-cycle reset during digit 2 with the shadow full.
    run_to(18);
    data = fd; valid = 1'b1;
    step();
    check("d_full", ready, 1'b0);
    valid = 1'b0;
    run_to(22);
    check("d2_en", en, 4'b1101);
    rst_n = 1'b0;
    step();
    check("mid_rst_en", en, 4'hF);
    check("mid_rst_seg", seg, 7'h00);
    check("mid_rst_ready", ready, 1'b0);
    rst_n = 1'b1; scan_en = 1'b0;
    step();
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_en", en, 4'hF);
    scan_en = 1'b1;
    step(); step(); step();
    check("cleared_en", en, 4'b1110);
    check("cleared_seg", seg, 7'h00);
    check("cleared_ready", ready, 1'b1);

`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
    // Brightness 7 lights each digit for 7 of 14 show cycles; 15 for all 14.
    do_reset();
    bright = 4'd7;
    data = vecs[0].frame; valid = 1'b1;
    step();
    valid = 1'b0; scan_en = 1'b1;
    step();
    lows = 0;
    for (int i = 0; i < D; i++) begin
      if (i == 8) check("pwm7_on", en, 4'b1110);
      if (i == 9) begin
        check("pwm7_off", en, 4'hF);
        check("pwm7_seg", seg, 7'h79);
      end
      if (en[0] == 1'b0) lows++;
      step();
    end
    check("pwm7_lows", lows, 7);
    bright = 4'd15;
    run_to(0);
    lows = 0;
    for (int i = 0; i < D; i++) begin
      if (en[0] == 1'b0) lows++;
      step();
    end
    check("pwm15_lows", lows, 14);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 499) != 0);
      scan_en = ($urandom_range(0, 149) != 0);
      valid   = ($urandom_range(0, 3) == 0);
      data    = 28'($urandom);
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
      bright  = 4'($urandom_range(0, 15));
`endif
      step();
      cmp_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Scheduler for the 4-digit multiplexed 7-segment display. It time-slices the shared segment bus between the four digit enables.
- Inserts a blanking interval at each digit switch to prevent ghosting.
- Accepts new 4-digit frames from upstream via a valid/ready handshake into a shadow buffer. The shadow buffer is applied only at frame boundaries, so the display never shows a torn frame.
- Replaces ad-hoc counter-bit scan clocks; runs entirely on the system clock.

Parameters:
- DWELL_CYCLES, 4096, CLK cycles per digit slot (blank + show); must be > BLANK_CYCLES and >= 4.
- BLANK_CYCLES, 64, cycles at the start of each slot with all digits disabled; must be >= 1.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  reset, synchronous, active-low.
- scan_enable  input  1  1 = scanning runs; 0 = display blanked, FSM idle.
- frame_data  input  28  {digit4, digit3, digit2, digit1}; each is 7 bits, {A,B,C,D,E,F,G}, MSB = A, 1 = segment lit.
- frame_valid  input  1  upstream has a frame on frame_data.
- frame_ready  output  1  shadow buffer empty; frame accepted when valid && ready.
- frame_tick  output  1  one-cycle pulse in the last show cycle of digit 4.
- DS_EN1, DS_EN2, DS_EN3, DS_EN4  output  1 each  digit enables, active-low (0 = digit on).
- DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G  output  1 each  segment drives for the current digit.

Behaviour:
- All state and outputs are flops. Every output reflects the state register in the same cycle.
- Reset (RST_N=0 at posedge):
  - state=IDLE, digit index=0, slot counter=0.
  - active frame=0, shadow empty, frame_ready=0.
  - DS_EN1..4=1, DS_A..G=0, frame_tick=0.
  - Pending shadow data is discarded. Reset asserted mid-frame wins over all other events.
- frame_ready = !shadow_full while out of reset. It is 1 the first cycle after reset release.
- Handshake:
  - On valid && ready, frame_data is captured into the shadow buffer and shadow_full is set.
  - frame_data must be held by upstream only until acceptance.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: all DS_EN=1, segments=0.
    - If scan_enable=1: load shadow into active if shadow_full (clear shadow_full), set digit index=0, go to BLANK.
  - BLANK: lasts BLANK_CYCLES cycles.
    - All DS_EN=1; segments already driven with the current digit's mask.
    - Then go to SHOW.
  - SHOW: lasts DWELL_CYCLES-BLANK_CYCLES cycles.
    - The DS_EN of the current digit = 0, others = 1; segments = active frame mask of the current digit.
    - At the end: digit index increments mod 4 (1->2->3->4->1), then go to BLANK.
- Frame boundary = last SHOW cycle of digit 4:
  - frame_tick=1 in that cycle.
  - If shadow_full, the shadow is copied to active on that edge and shadow_full is cleared. frame_ready rises the next cycle.
- Simultaneous events at the boundary edge:
  - A frame accepted in the boundary cycle goes to the shadow buffer (only possible if it was empty); it is not applied until the next boundary.
  - The boundary load reads only the pre-edge shadow contents.
- scan_enable=0 in any non-IDLE state:
  - Next cycle: IDLE, all digits off, digit index=0, slot counter=0.
  - The active frame is retained and the shadow is kept.
  - No frame_tick is generated for the abandoned frame.
- Frame period = 4*DWELL_CYCLES. The first DS_EN1=0 occurs BLANK_CYCLES+1 cycles after scan_enable rises from IDLE.
- Slot counter width is $clog2(DWELL_CYCLES). It wraps to 0 at each slot end; no other wrap is permitted.

Optional Feature:
- Macro SEG_SCAN_BRIGHTNESS_PWM_EN.
- When defined:
  - Adds input brightness[3:0], sampled into a register at each frame boundary and on IDLE->BLANK.
  - Within SHOW, the digit enable is 0 only while show_count < ((brightness_reg+1)*(DWELL_CYCLES-BLANK_CYCLES))>>4. It is 1 for the rest of SHOW; segments are unchanged.
  - brightness=15 is identical to no-PWM behaviour.
  - Reset value of brightness_reg = 15.
- When undefined: no port; the digit is enabled for the whole SHOW phase.

Test Plan:
All scenarios use DWELL_CYCLES=16 and BLANK_CYCLES=2.
- Reset with scan_enable=1 and frame_valid=1 held -> during reset, DS_EN1..4=1111, segs=0, frame_ready=0; first cycle after release frame_ready=1.
- Load frame 28'h7E_30_6D_79 from IDLE, then scan_enable=1 -> per slot: 2 cycles all-off, then 14 cycles with one enable low in order EN1,EN2,EN3,EN4. Segments are 0x79, 0x6D, 0x30, 0x7E respectively. frame_tick pulses every 64 cycles.
- Mid-frame, offer frame B, then frame C held valid -> B accepted immediately and frame_ready drops. C is stalled until the boundary after frame_tick. B appears on digit 1 only in the frame after that boundary.
- Drop scan_enable during digit 3 SHOW -> next cycle all DS_EN=1 and no frame_tick. On re-enable, digit 1 shows after 2 blank cycles with the retained frame.
- Assert RST_N=0 for 1 cycle with the shadow full during digit 2 -> state IDLE, frame cleared to 0, frame_ready=1 the next cycle.
- SEG_SCAN_BRIGHTNESS_PWM_EN with brightness=7 -> each digit low for (8*14)>>4 = 7 cycles, then high for 7 cycles; brightness=15 -> low for 14 cycles.
